// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings and baud helper
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  function automatic int clks_per_bit(input int clk, input int baud);
    return clk / baud;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser with selectable reset level
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {2{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with parity/framing/break reporting
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int LSB_FIRST = 1
) (
  input  logic                 clk_50M,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_break,
  output logic                 rx_busy
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
  localparam int HALF  = CPB / 2;
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic             TWO_STOP = (STOP_BITS == 2);

  logic rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk_50M),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 stop_err_q, stop_err_d;
  logic                 stop0_q, stop0_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 rx_break_q, rx_break_d;
  logic [DATA_BITS-1:0] shift_in;
  logic                 par_xor;
  logic                 stop_first;

  always_comb begin
    if (LSB_FIRST != 0) shift_in = {rx_s, shift_q[DATA_BITS-1:1]};
    else                shift_in = {shift_q[DATA_BITS-2:0], rx_s};
    par_xor    = (^shift_q) ^ par_bit_q;
    // With two stop bits the first sample was stashed; otherwise it is the current one
    stop_first = (stop_idx_q == 1'b1) ? stop0_q : rx_s;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    stop_idx_d   = stop_idx_q;
    stop_err_d   = stop_err_q;
    stop0_d      = stop0_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    rx_break_d   = rx_break_q;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d    = ST_START;
          cnt_d      = '0;
          bit_d      = '0;
          par_bit_d  = 1'b0;
          stop_idx_d = 1'b0;
          stop_err_d = 1'b0;
          stop0_d    = 1'b1;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = shift_in;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bit_d = rx_s;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d      = '0;
          stop_err_d = stop_err_q | ~rx_s;
          if (stop_idx_q == TWO_STOP) begin
            rx_valid_d   = 1'b1;
            rx_data_d    = shift_q;
            frame_err_d  = stop_err_q | ~rx_s;
            parity_err_d = (PARITY == PAR_EVEN) ? par_xor :
                           (PARITY == PAR_ODD)  ? ~par_xor : 1'b0;
            rx_break_d   = (shift_q == '0) && !par_bit_q && !stop_first;
            state_d      = rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            stop0_d    = rx_s;
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      stop_idx_q   <= 1'b0;
      stop_err_q   <= 1'b0;
      stop0_q      <= 1'b1;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rx_break_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      stop_idx_q   <= stop_idx_d;
      stop_err_q   <= stop_err_d;
      stop0_q      <= stop0_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      rx_break_q   <= rx_break_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign rx_break   = rx_break_q;
  assign rx_busy    = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the team's fixed 8N1 receiver.
- Configurable data width, parity mode, stop-bit count and bit order; baud divisor derived from clock frequency.
- Input synchroniser, mid-bit sampling, false-start rejection, parity/framing/break error reporting.
- Sits between the board RX pin and the command-decode logic; delivers one word per frame with a single-cycle valid strobe.

Parameters:
CLK_FREQ, 50000000, input clock frequency in Hz
BAUD, 115200, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults), must be >= 4
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
LSB_FIRST, 1, 1 = first data bit received is bit 0; 0 = first data bit is bit DATA_BITS-1

Ports:
clk_50M  input  1  system clock
rst_n  input  1  asynchronous active-low reset
rx  input  1  raw serial line, idle high, asynchronous to clk_50M
rx_data  output  DATA_BITS  last received word, right-justified, held until the next frame completes
rx_valid  output  1  one-cycle pulse: rx_data and error flags updated
parity_err  output  1  parity mismatch on the frame reported by rx_valid (0 when PARITY = 0)
frame_err  output  1  a stop bit was sampled low
rx_break  output  1  data all zero, parity bit (if present) zero, first stop bit low
rx_busy  output  1  high in every state except IDLE

Behaviour:
- Reset, async assert / sync release: all outputs 0, state IDLE, counters 0, both synchroniser flops 1 (line idle, so release never produces a false start).
- rx passes through a 2-flop synchroniser; rx_s is its output. All references to "rx" below mean rx_s.
- Baud counter width is $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE: rx_s == 0 -> START, counter cleared.
- START: count to HALF-1, then sample.
  - rx_s == 1 -> glitch; return to IDLE, no rx_valid.
  - Otherwise clear counter, go to DATA.
- DATA: every CLKS_PER_BIT cycles sample one bit into the shift register (direction per LSB_FIRST). After DATA_BITS samples go to PARITY if PARITY != 0, else STOP.
- PARITY: one sample after CLKS_PER_BIT cycles.
  - Even: error if XOR(data, bit) = 1.
  - Odd: error if XOR(data, bit) = 0.
- STOP: STOP_BITS samples, each CLKS_PER_BIT apart. Any low stop sample sets frame_err for this frame. Both stop bits are checked when STOP_BITS = 2.
- Completion: the cycle after the final stop sample:
  - rx_data, parity_err, frame_err and rx_break are loaded;
  - rx_valid = 1 for exactly one cycle.
  - Next state is IDLE if the final stop sample was 1, else WAIT_HIGH.
- Error flags are level outputs: they remain until the next completion overwrites them.
- WAIT_HIGH: stay until rx_s == 1, then IDLE. Prevents a held-low line (break) from re-triggering frames.
- Back-to-back frames: a start edge arriving as early as half a bit after the last stop sample must be captured. IDLE is re-entered at completion, so there is no dead time beyond 1 cycle.
- Latency: rx_valid rises 3 cycles (2 sync + 1 register) after the mid-point of the last stop bit on the pin.
- rst_n asserted mid-frame: partial frame discarded, no rx_valid; rx_data returns to 0.
- rx toggling during the non-sampled portion of a bit has no effect. Only the single mid-bit sample counts.

Decomposition:
- Shared package uart_pkg:
  - parity encodings PAR_NONE / PAR_EVEN / PAR_ODD;
  - rx state encodings;
  - constant function clks_per_bit(clk, baud).
- Sub-module uart_sync2: 2-flop synchroniser with parameterised reset value (1 here). It will be reused by the transmitter's CTS input.

Test Plan:
- Defaults, send 8N1 byte 0xA5 LSB-first at 434 clk/bit -> one rx_valid pulse, rx_data = 8'hA5, parity_err = frame_err = rx_break = 0.
- Low glitch on rx of 100 cycles in IDLE -> no rx_valid; rx_busy returns low within HALF + 3 cycles.
- PARITY = 1, DATA_BITS = 7, send 0x35 with parity bit 1 (wrong; correct is 0) -> rx_data = 7'h35, parity_err = 1; then a correct frame clears parity_err.
- Stop bit driven low, line then held low 20 bit times -> frame_err = 1 and rx_break = 1 on a single rx_valid. No further rx_valid until rx returns high and a new frame arrives.
- STOP_BITS = 2, LSB_FIRST = 0, back-to-back frames 0x81 and 0x7E with zero idle gap -> two rx_valid pulses with rx_data = 8'h81 then 8'h7E, no errors.
- rst_n pulsed low mid-way through the DATA state of frame 0x3C, next frame 0xC3 -> no rx_valid for 0x3C, rx_data = 0 after reset, then rx_data = 8'hC3 correctly received.
